// File: rtl/wave_mixer_pwm.sv
// wave_mixer_pwm
// Mixes NUM_CH phase-accumulator waveforms (saw-up, saw-down, triangle,
// square) into one PWM output. The duty cycle is the integer average of the
// enabled channels' amplitudes.
//
// Ports
//   Local_clk     single clock, rising edge
//   Reset_n       asynchronous active-low reset
//   Enable_SW     per-channel enable, bit i = channel i
//   Mode          per-channel waveform select, bits [2i+1:2i]
//                 0 saw-up, 1 saw-down, 2 triangle, 3 square
//   Step          per-channel phase increment per PWM period, STEP_W bits each
//   Pulse         PWM output, high while cnt < Duty_Level
//   Period_Start  one-cycle strobe in the cycle where the PWM counter is 0
//   Duty_Level    duty applied during the current PWM period
//
// Timing: in each period the enables, modes and phases are captured when
// cnt==0. The average is computed during that period and goes live on the
// next wrap edge, so it applies throughout the following period.
//
// state | meaning
// IDLE  | waiting for cnt==0, when inputs and phases are captured
// SUM   | one channel per cycle: add a_i to S and count enabled channels
// DIV   | restoring divide S/n, one quotient bit per cycle
// DONE  | quotient held until the wrap edge loads it into Duty_Level
module wave_mixer_pwm #(
  parameter int NUM_CH  = 4,
  parameter int PWM_W   = 6,
  parameter int PHASE_W = 10,
  parameter int STEP_W  = 8
) (
  input  logic                       Local_clk,
  input  logic                       Reset_n,
  input  logic [NUM_CH-1:0]          Enable_SW,
  input  logic [2*NUM_CH-1:0]        Mode,
  input  logic [STEP_W*NUM_CH-1:0]   Step,
  output logic                       Pulse,
  output logic                       Period_Start,
  output logic [PWM_W-1:0]           Duty_Level
);

  localparam int N_W   = $clog2(NUM_CH + 1);
  localparam int S_W   = PWM_W + N_W;
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BC_W  = $clog2(S_W);

  if (NUM_CH < 1 || NUM_CH > 8 || PHASE_W < PWM_W + 1 || STEP_W > PHASE_W ||
      NUM_CH + S_W + 2 > (1 << PWM_W)) begin : g_bad_params
    $error("wave_mixer_pwm: unsupported parameter set");
  end

  typedef enum logic [1:0] {IDLE, SUM, DIV, DONE} state_t;

  state_t             state;
  logic [PWM_W-1:0]   cnt;
  logic [PHASE_W-1:0] phase [NUM_CH];
  // Only the top PWM_W+1 phase bits feed the amplitude, so only those are captured.
  logic [PWM_W:0]     snap_top  [NUM_CH];
  logic [1:0]         snap_mode [NUM_CH];
  logic [NUM_CH-1:0]  snap_en;
  logic [IDX_W-1:0]   idx;
  logic [S_W-1:0]     sum_s;
  logic [N_W-1:0]     n_en;
  logic [S_W-1:0]     dvd;
  logic [N_W-1:0]     rem;
  logic [PWM_W-1:0]   quo;
  logic [BC_W-1:0]    bit_cnt;

  logic               wrap;
  logic               cnt_zero;
  logic [PWM_W-1:0]   amp;
  logic [S_W-1:0]     sum_nx;
  logic [N_W-1:0]     n_nx;
  logic [N_W:0]       rem_sh;
  logic               q_bit;
  logic [N_W-1:0]     rem_nx;

  assign wrap     = &cnt;
  assign cnt_zero = (cnt == '0);
  assign Pulse    = (cnt < Duty_Level);

  // Amplitude of the channel currently being summed.
  always_comb begin
    logic [PWM_W:0] top;
    top = snap_top[idx];
    amp = '0;
    case (snap_mode[idx])
      2'd0: amp = top[PWM_W:1];
      2'd1: amp = ~top[PWM_W:1];
      2'd2: amp = top[PWM_W] ? ~top[PWM_W-1:0] : top[PWM_W-1:0];
      default: amp = top[PWM_W] ? '0 : '1;
    endcase
  end

  assign sum_nx = snap_en[idx] ? sum_s + S_W'(amp) : sum_s;
  assign n_nx   = n_en + N_W'(snap_en[idx]);

  // Restoring divide step: the remainder stays below n, so N_W bits hold it.
  assign rem_sh = {rem, dvd[S_W-1]};
  assign q_bit  = (rem_sh >= {1'b0, n_en});
  assign rem_nx = q_bit ? N_W'(rem_sh - {1'b0, n_en}) : rem_sh[N_W-1:0];

  always_ff @(posedge Local_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt          <= '1;
      Period_Start <= 1'b0;
      Duty_Level   <= '0;
      state        <= IDLE;
      idx          <= '0;
      sum_s        <= '0;
      n_en         <= '0;
      dvd          <= '0;
      rem          <= '0;
      quo          <= '0;
      bit_cnt      <= '0;
      snap_en      <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        phase[i]     <= '0;
        snap_top[i]  <= '0;
        snap_mode[i] <= '0;
      end
    end else begin
      cnt          <= cnt + 1'b1;
      Period_Start <= wrap;

      if (wrap) begin
        Duty_Level <= quo;
        for (int i = 0; i < NUM_CH; i++) begin
          phase[i] <= Enable_SW[i] ? phase[i] + PHASE_W'(Step[i*STEP_W +: STEP_W]) : '0;
        end
      end

      case (state)
        IDLE: begin
          if (cnt_zero) begin
            snap_en <= Enable_SW;
            for (int i = 0; i < NUM_CH; i++) begin
              snap_top[i]  <= phase[i][PHASE_W-1 -: PWM_W+1];
              snap_mode[i] <= Mode[2*i +: 2];
            end
            idx   <= '0;
            sum_s <= '0;
            n_en  <= '0;
            state <= SUM;
          end
        end
        SUM: begin
          sum_s <= sum_nx;
          n_en  <= n_nx;
          if (idx == IDX_W'(NUM_CH - 1)) begin
            quo     <= '0;
            rem     <= '0;
            dvd     <= sum_nx;
            bit_cnt <= '0;
            // No enabled channel: the quotient is simply zero.
            state   <= (n_nx == '0) ? DONE : DIV;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DIV: begin
          dvd     <= dvd << 1;
          rem     <= rem_nx;
          // Quotient never exceeds the largest amplitude, so the upper
          // quotient bits shifted out are always zero.
          quo     <= {quo[PWM_W-2:0], q_bit};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == BC_W'(S_W - 1)) state <= DONE;
        end
        DONE: begin
          if (wrap) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
